// File: rtl/aemb_wb_arbiter.sv
// aemb_wb_arbiter
//   Shares one Wishbone-style slave port between the aeMB instruction bus
//   (iwb, read-only) and data bus (dwb). Round-robin arbitration between
//   simultaneous requests, direct hand-off on ack with no dead cycle, and a
//   watchdog that terminates transfers the slave never acknowledges.
//
// Ports
//   sys_clk_i, sys_rst_i        clock, asynchronous active-high reset
//   iwb_*                       instruction master (stb/adr in, dat/ack out)
//   dwb_*                       data master (stb/wre/sel/adr/dat in, dat/ack out)
//   xwb_*                       shared slave port
//   gnt_o                       01 = iwb granted, 10 = dwb granted, 00 = idle
//   err_o                       one-cycle pulse when the watchdog fires
//
// States
//   S_IDLE | no master granted, slave strobe low
//   S_GI   | instruction master owns the slave port
//   S_GD   | data master owns the slave port

module aemb_wb_arbiter #(
  parameter int AW   = 14,
  parameter int DW   = 32,
  parameter int TOUT = 255
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [AW-1:0] iwb_adr_i,
  output logic [DW-1:0] iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-1:0] dwb_adr_i,
  input  logic [DW-1:0] dwb_dat_i,
  output logic [DW-1:0] dwb_dat_o,
  output logic          dwb_ack_o,
  output logic          xwb_stb_o,
  output logic          xwb_wre_o,
  output logic [3:0]    xwb_sel_o,
  output logic [AW-1:0] xwb_adr_o,
  output logic [DW-1:0] xwb_dat_o,
  input  logic [DW-1:0] xwb_dat_i,
  input  logic          xwb_ack_i,
  output logic [1:0]    gnt_o,
  output logic          err_o
);

  // A zero-width counter is illegal, so a disabled watchdog keeps one bit.
  localparam int CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(TOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GI   = 2'd1,
    S_GD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_dwb_q, last_dwb_d;  // 1: dwb was served last
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            granted;
  logic            tmo;
  logic            done;

  assign granted = (state_q != S_IDLE);
  // Gated by granted so that TOUT=1 (limit 0) cannot fire while idle.
  assign tmo     = (TOUT != 0) && granted && (cnt_q == CNT_LIM) && !xwb_ack_i;
  assign done    = granted && (xwb_ack_i || tmo);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iwb_stb_i && dwb_stb_i) state_d = last_dwb_q ? S_GI : S_GD;
        else if (iwb_stb_i)         state_d = S_GI;
        else if (dwb_stb_i)         state_d = S_GD;
      end
      // On completion the finishing master's stb is still high, so only the
      // other master is considered for an immediate hand-off.
      S_GI: begin
        if (done)            state_d = dwb_stb_i ? S_GD : S_IDLE;
        else if (!iwb_stb_i) state_d = S_IDLE;
      end
      S_GD: begin
        if (done)            state_d = iwb_stb_i ? S_GI : S_IDLE;
        else if (!dwb_stb_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o     = 2'b00;
    xwb_stb_o = 1'b0;
    xwb_wre_o = 1'b0;
    xwb_sel_o = dwb_sel_i;
    xwb_adr_o = dwb_adr_i;
    xwb_dat_o = dwb_dat_i;
    iwb_ack_o = 1'b0;
    dwb_ack_o = 1'b0;
    err_o     = tmo;
    iwb_dat_o = tmo ? '0 : xwb_dat_i;
    dwb_dat_o = tmo ? '0 : xwb_dat_i;
    case (state_q)
      S_GI: begin
        gnt_o     = 2'b01;
        xwb_stb_o = iwb_stb_i && !tmo;
        xwb_sel_o = 4'hF;
        xwb_adr_o = iwb_adr_i;
        iwb_ack_o = xwb_ack_i || tmo;
      end
      S_GD: begin
        gnt_o     = 2'b10;
        xwb_stb_o = dwb_stb_i && !tmo;
        xwb_wre_o = dwb_wre_i;
        dwb_ack_o = xwb_ack_i || tmo;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_dwb_d = last_dwb_q;
    if (done) last_dwb_d = (state_q == S_GD);
  end

  // Counter holds zero while idle and after every completion, so each grant
  // starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!granted || done)      cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      last_dwb_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      last_dwb_q <= last_dwb_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
module tb_aemb_wb_arbiter;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i;
  logic        iwb_stb_i;
  logic [13:0] iwb_adr_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic        dwb_stb_i;
  logic        dwb_wre_i;
  logic [3:0]  dwb_sel_i;
  logic [13:0] dwb_adr_i;
  logic [31:0] dwb_dat_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o;
  logic        xwb_stb_o;
  logic        xwb_wre_o;
  logic [3:0]  xwb_sel_o;
  logic [13:0] xwb_adr_o;
  logic [31:0] xwb_dat_o;
  logic [31:0] xwb_dat_i;
  logic        xwb_ack_i;
  logic [1:0]  gnt_o;
  logic        err_o;

  aemb_wb_arbiter #(.AW(14), .DW(32), .TOUT(4)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .iwb_stb_i(iwb_stb_i), .iwb_adr_i(iwb_adr_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .dwb_stb_i(dwb_stb_i), .dwb_wre_i(dwb_wre_i), .dwb_sel_i(dwb_sel_i), .dwb_adr_i(dwb_adr_i),
    .dwb_dat_i(dwb_dat_i), .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o),
    .xwb_stb_o(xwb_stb_o), .xwb_wre_o(xwb_wre_o), .xwb_sel_o(xwb_sel_o), .xwb_adr_o(xwb_adr_o),
    .xwb_dat_o(xwb_dat_o), .xwb_dat_i(xwb_dat_i), .xwb_ack_i(xwb_ack_i),
    .gnt_o(gnt_o), .err_o(err_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   checks = 0;
  int   fails  = 0;
  logic slave_en = 1'b0;
  logic mon_en   = 1'b0;
  int   scnt     = 0;
  logic pend     = 1'b0;
  logic [1:0] exp_gnt;
  logic last_dwb_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Slave read data is a fixed function of the word address.
  function automatic logic [31:0] hsh(input logic [13:0] a);
    return {a, 2'b01, ~a, 2'b10};
  endfunction

  // Slave behaviour: address bits [1:0] give the wait cycles before ack,
  // address [3:0]==F never acks (the watchdog must terminate it).
  always @(negedge sys_clk_i) begin
    if (xwb_stb_o && !xwb_ack_i) scnt++;
    else                         scnt = 0;
  end

  always @(posedge sys_clk_i) begin
    #3;
    if (slave_en) begin
      if (gnt_o != 2'b00 && xwb_adr_o[3:0] != 4'hF && scnt == int'(xwb_adr_o[1:0])) begin
        xwb_ack_i = 1'b1;
        xwb_dat_i = hsh(xwb_adr_o);
      end else begin
        xwb_ack_i = 1'b0;
        xwb_dat_i = $urandom;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge sys_clk_i) begin
    exp_t e;
    if (!mon_en) begin
      pend = 1'b0;
    end else begin
      chk("ack_exclusive", {31'd0, iwb_ack_o & dwb_ack_o}, 32'd0);
      chk("err_without_ack", {31'd0, err_o & ~(iwb_ack_o | dwb_ack_o)}, 32'd0);
      if (pend) begin
        chk("next_grant", {30'd0, gnt_o}, {30'd0, exp_gnt});
        pend = 1'b0;
      end
      if (iwb_ack_o) begin
        chk("iwb_ack_grant", {30'd0, gnt_o}, 32'd1);
        if (iq.size() == 0) begin
          checks++; fails++;
          $display("FAIL iwb_unexpected_ack actual=ack expected=no_ack time=%0t", $time);
        end else begin
          e = iq.pop_front();
          chk("iwb_dat", iwb_dat_o, e.dat);
          chk("iwb_err", {31'd0, err_o}, {31'd0, e.err});
        end
      end
      if (dwb_ack_o) begin
        chk("dwb_ack_grant", {30'd0, gnt_o}, 32'd2);
        if (dq.size() == 0) begin
          checks++; fails++;
          $display("FAIL dwb_unexpected_ack actual=ack expected=no_ack time=%0t", $time);
        end else begin
          e = dq.pop_front();
          chk("dwb_dat", dwb_dat_o, e.dat);
          chk("dwb_err", {31'd0, err_o}, {31'd0, e.err});
        end
      end
      if (xwb_ack_i && gnt_o == 2'b01) begin
        chk("slv_i_adr", {18'd0, xwb_adr_o}, {18'd0, iwb_adr_i});
        chk("slv_i_wre_sel_stb", {26'd0, xwb_wre_o, xwb_sel_o, xwb_stb_o}, {26'd0, 1'b0, 4'hF, 1'b1});
      end
      if (xwb_ack_i && gnt_o == 2'b10) begin
        chk("slv_d_adr", {18'd0, xwb_adr_o}, {18'd0, dwb_adr_i});
        chk("slv_d_wre_sel_stb", {26'd0, xwb_wre_o, xwb_sel_o, xwb_stb_o},
            {26'd0, dwb_wre_i, dwb_sel_i, 1'b1});
        chk("slv_d_dat", xwb_dat_o, dwb_dat_i);
      end
      // Grant rules: after a completion, only the other master may follow;
      // from idle, simultaneous requests go to whoever was not served last.
      if (iwb_ack_o || dwb_ack_o) begin
        last_dwb_m = dwb_ack_o;
        if (dwb_ack_o) exp_gnt = iwb_stb_i ? 2'b01 : 2'b00;
        else           exp_gnt = dwb_stb_i ? 2'b10 : 2'b00;
        pend = 1'b1;
      end else if (gnt_o == 2'b00 && (iwb_stb_i || dwb_stb_i)) begin
        if (iwb_stb_i && dwb_stb_i) exp_gnt = last_dwb_m ? 2'b01 : 2'b10;
        else                        exp_gnt = iwb_stb_i ? 2'b01 : 2'b10;
        pend = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk_i); #2;
  endtask

  task automatic smp();
    @(negedge sys_clk_i);
  endtask

  task automatic clear_inputs();
    iwb_stb_i = 0; iwb_adr_i = 0;
    dwb_stb_i = 0; dwb_wre_i = 0; dwb_sel_i = 0; dwb_adr_i = 0; dwb_dat_i = 0;
    xwb_ack_i = 0; xwb_dat_i = 0;
  endtask

  task automatic reset_pulse();
    tick(); sys_rst_i = 1'b1; clear_inputs();
    tick(); sys_rst_i = 1'b0;
  endtask

  task automatic run_iwb(input int n);
    exp_t e;
    logic [13:0] a;
    int k;
    for (int t = 0; t < n; t++) begin
      tick();
      repeat ($urandom_range(0, 3)) begin iwb_stb_i = 1'b0; tick(); end
      a = 14'($urandom);
      e.err = (a[3:0] == 4'hF);
      e.dat = e.err ? 32'd0 : hsh(a);
      iq.push_back(e);
      iwb_adr_i = a; iwb_stb_i = 1'b1;
      k = 0;
      do begin smp(); k++; end while (!iwb_ack_o && k < 60);
      if (!iwb_ack_o) begin
        checks++; fails++;
        $display("FAIL iwb_ack_timeout actual=no_ack expected=ack time=%0t", $time);
      end
    end
    tick(); iwb_stb_i = 1'b0;
  endtask

  task automatic run_dwb(input int n);
    exp_t e;
    logic [13:0] a;
    int k;
    for (int t = 0; t < n; t++) begin
      tick();
      repeat ($urandom_range(0, 3)) begin dwb_stb_i = 1'b0; tick(); end
      a = 14'($urandom);
      e.err = (a[3:0] == 4'hF);
      e.dat = e.err ? 32'd0 : hsh(a);
      dq.push_back(e);
      dwb_adr_i = a; dwb_wre_i = 1'($urandom); dwb_sel_i = 4'($urandom_range(1, 15));
      dwb_dat_i = $urandom; dwb_stb_i = 1'b1;
      k = 0;
      do begin smp(); k++; end while (!dwb_ack_o && k < 60);
      if (!dwb_ack_o) begin
        checks++; fails++;
        $display("FAIL dwb_ack_timeout actual=no_ack expected=ack time=%0t", $time);
      end
    end
    tick(); dwb_stb_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int nack, gaps, cyc;
    logic started;
    logic [1:0] seq [8];

    sys_rst_i = 1'b1;
    clear_inputs();
    #3;
    chk("rst_outputs", {24'd0, xwb_stb_o, xwb_wre_o, iwb_ack_o, dwb_ack_o, err_o, 1'b0, gnt_o}, 32'd0);
    #20;
    tick(); sys_rst_i = 1'b0;

    // Single instruction read, ack in the 2nd granted cycle
    tick(); iwb_stb_i = 1; iwb_adr_i = 14'h0010;
    smp(); chk("t1_arb_latency", {30'd0, gnt_o}, 32'd0);
    chk("t1_stb_before_grant", {31'd0, xwb_stb_o}, 32'd0);
    tick(); smp();
    chk("t1_stb", {31'd0, xwb_stb_o}, 32'd1);
    chk("t1_adr", {18'd0, xwb_adr_o}, 32'h0010);
    chk("t1_sel_wre", {27'd0, xwb_sel_o, xwb_wre_o}, {27'd0, 4'hF, 1'b0});
    chk("t1_gnt", {30'd0, gnt_o}, 32'd1);
    chk("t1_no_early_ack", {31'd0, iwb_ack_o}, 32'd0);
    tick(); xwb_ack_i = 1; xwb_dat_i = 32'hB8000000;
    smp();
    chk("t1_ack", {30'd0, iwb_ack_o, dwb_ack_o}, 32'd2);
    chk("t1_dat", iwb_dat_o, 32'hB8000000);
    chk("t1_err", {31'd0, err_o}, 32'd0);
    tick(); iwb_stb_i = 0; xwb_ack_i = 0;
    smp(); chk("t1_idle", {30'd0, gnt_o}, 32'd0);

    // Byte write on the data master
    tick(); dwb_stb_i = 1; dwb_wre_i = 1; dwb_sel_i = 4'h2; dwb_dat_i = 32'h0000AB00; dwb_adr_i = 14'h3FF4;
    smp(); tick(); smp();
    chk("t3_gnt", {30'd0, gnt_o}, 32'd2);
    chk("t3_wre_sel", {27'd0, xwb_wre_o, xwb_sel_o}, {27'd0, 1'b1, 4'h2});
    chk("t3_dat", xwb_dat_o, 32'h0000AB00);
    chk("t3_adr", {18'd0, xwb_adr_o}, 32'h3FF4);
    tick(); xwb_ack_i = 1;
    smp(); chk("t3_acks", {30'd0, iwb_ack_o, dwb_ack_o}, 32'd1);
    tick(); dwb_stb_i = 0; dwb_wre_i = 0; xwb_ack_i = 0;
    smp(); chk("t3_idle", {30'd0, gnt_o}, 32'd0);

    // Watchdog termination, slave never acks
    tick(); dwb_stb_i = 1; dwb_adr_i = 14'h0020; dwb_sel_i = 4'hF; xwb_dat_i = 32'hDEADBEEF;
    smp();
    for (int c = 1; c <= 3; c++) begin
      tick(); smp();
      chk("t4_wait", {28'd0, gnt_o, dwb_ack_o, err_o}, {28'd0, 2'b10, 1'b0, 1'b0});
    end
    tick(); smp();
    chk("t4_tmo_ack_err", {30'd0, dwb_ack_o, err_o}, 32'd3);
    chk("t4_tmo_dat", dwb_dat_o, 32'd0);
    chk("t4_tmo_stb", {31'd0, xwb_stb_o}, 32'd0);
    tick(); dwb_stb_i = 0;
    smp(); chk("t4_after", {29'd0, err_o, gnt_o}, 32'd0);

    // Ack arriving exactly at the watchdog limit wins
    tick(); dwb_stb_i = 1;
    smp();
    repeat (3) begin tick(); smp(); end
    tick(); xwb_ack_i = 1;
    smp();
    chk("t5_ack_err", {30'd0, dwb_ack_o, err_o}, 32'd2);
    chk("t5_dat", dwb_dat_o, 32'hDEADBEEF);
    tick(); dwb_stb_i = 0; xwb_ack_i = 0;
    smp(); chk("t5_idle", {30'd0, gnt_o}, 32'd0);

    // Abandonment: granted master drops stb without ack
    tick(); iwb_stb_i = 1; iwb_adr_i = 14'h0100;
    smp(); tick(); smp(); chk("ab_gnt", {30'd0, gnt_o}, 32'd1);
    tick(); iwb_stb_i = 0;
    smp(); chk("ab_stb_ack", {30'd0, xwb_stb_o, iwb_ack_o}, 32'd0);
    tick(); smp(); chk("ab_idle", {30'd0, gnt_o}, 32'd0);

    // Reset mid-transfer (dwb was served last before this point)
    tick(); iwb_stb_i = 1; iwb_adr_i = 14'h0044;
    smp(); tick(); smp(); chk("t6_gnt", {30'd0, gnt_o}, 32'd1);
    tick(); xwb_ack_i = 1;
    smp(); chk("t6_pre_ack", {31'd0, iwb_ack_o}, 32'd1);
    #1; sys_rst_i = 1; dwb_stb_i = 1;
    #1; chk("t6_rst_async", {29'd0, xwb_stb_o, iwb_ack_o, gnt_o[1] | gnt_o[0]}, 32'd0);
    tick(); xwb_ack_i = 0; sys_rst_i = 0;
    smp(); chk("t6_idle_after", {30'd0, gnt_o}, 32'd0);
    tick(); smp(); chk("t6_dwb_first", {30'd0, gnt_o}, 32'd2);

    // Simultaneous requests: strict alternation starting with dwb
    reset_pulse();
    slave_en = 1;
    iwb_adr_i = 14'h0001; dwb_adr_i = 14'h0001; iwb_stb_i = 1; dwb_stb_i = 1;
    nack = 0; gaps = 0; cyc = 0; started = 0;
    for (int k = 0; k < 8; k++) seq[k] = 2'b00;
    while (nack < 8 && cyc < 100) begin
      smp(); cyc++;
      if (gnt_o != 2'b00) started = 1;
      else if (started) gaps++;
      if (iwb_ack_o || dwb_ack_o) begin
        seq[nack] = {dwb_ack_o, iwb_ack_o};
        nack++;
      end
    end
    chk("t2_ack_count", nack, 32'd8);
    for (int k = 0; k < 8; k++)
      chk("t2_order", {30'd0, seq[k]}, (k % 2 == 0) ? 32'd2 : 32'd1);
    chk("t2_no_idle_gap", gaps, 32'd0);
    tick(); iwb_stb_i = 0; dwb_stb_i = 0;

    // Randomized traffic against the scoreboard
    reset_pulse();
    last_dwb_m = 1'b0;
    mon_en = 1;
    fork
      run_iwb(40);
      run_dwb(40);
    join
    repeat (10) tick();
    chk("iq_drained", iq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);
    mon_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
